// File: rtl/idex_stage_pkg.sv
// Shared pipeline definitions: operand/register widths and the control-word layout
// used by the ID/EX and EX/MEM stages and the forwarding unit.
package idex_stage_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 2;
  localparam int CNT_W  = 8;
  localparam int CTRL_W = 9;

  // Bit positions inside the control word {RegWrite..ALUOp[1:0]}
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP    = 0;
  localparam int CTRL_ALUOP_W  = 2;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/idex_stage_if.sv
// ID -> EX boundary bundle: decoded ID fields in, registered EX fields and
// hazard controls out.
interface idex_stage_if
  import idex_stage_pkg::*;
#(
  parameter int DATA_W = idex_stage_pkg::DATA_W,
  parameter int REG_W  = idex_stage_pkg::REG_W,
  parameter int CNT_W  = idex_stage_pkg::CNT_W
) ();

  logic [REG_W-1:0]  ifid_rs;
  logic [REG_W-1:0]  ifid_rt;
  logic [REG_W-1:0]  ifid_rd;
  logic [DATA_W-1:0] ifid_rd1;
  logic [DATA_W-1:0] ifid_rd2;
  logic [DATA_W-1:0] ifid_imm;
  ctrl_t             ifid_ctrl;
  logic              ifid_valid;
  logic              flush;

  logic [REG_W-1:0]  idex_rs;
  logic [REG_W-1:0]  idex_rt;
  logic [REG_W-1:0]  idex_rd;
  logic [DATA_W-1:0] idex_rd1;
  logic [DATA_W-1:0] idex_rd2;
  logic [DATA_W-1:0] idex_imm;
  ctrl_t             idex_ctrl;
  logic              idex_valid;
  logic              stall;
  logic              pc_write;
  logic              ifid_write;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output ifid_rs, ifid_rt, ifid_rd, ifid_rd1, ifid_rd2, ifid_imm,
           ifid_ctrl, ifid_valid, flush,
    input  idex_rs, idex_rt, idex_rd, idex_rd1, idex_rd2, idex_imm,
           idex_ctrl, idex_valid, stall, pc_write, ifid_write, bubble_count
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_rd, ifid_rd1, ifid_rd2, ifid_imm,
           ifid_ctrl, ifid_valid, flush,
    output idex_rs, idex_rt, idex_rd, idex_rd1, idex_rd2, idex_imm,
           idex_ctrl, idex_valid, stall, pc_write, ifid_write, bubble_count
  );

endinterface

// File: rtl/idex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is a source of the
// instruction in ID freezes PC and IF/ID for one cycle. A flush overrides it.
module idex_stage_hazard_detect #(
  parameter int REG_W = idex_stage_pkg::REG_W
) (
  input  logic             idex_valid,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             ifid_valid,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             flush,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write
);

  logic hazard;

  // r0 is hard-wired zero, so a load targeting it never produces a dependency.
  assign hazard = idex_valid & idex_mem_read & (idex_rt != '0) & ifid_valid &
                  ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  assign stall      = hazard & ~flush;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squashing and a
// saturating count of inserted bubbles.
module idex_stage
  import idex_stage_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  idex_stage_if.slave  bus
);

  logic kill;
  logic count_bubble;

  idex_stage_hazard_detect #(.REG_W(REG_W)) u_hazard (
    .idex_valid    (bus.idex_valid),
    .idex_mem_read (bus.idex_ctrl[CTRL_MEMREAD]),
    .idex_rt       (bus.idex_rt),
    .ifid_valid    (bus.ifid_valid),
    .ifid_rs       (bus.ifid_rs),
    .ifid_rt       (bus.ifid_rt),
    .flush         (bus.flush),
    .stall         (bus.stall),
    .pc_write      (bus.pc_write),
    .ifid_write    (bus.ifid_write)
  );

  // Squashing clears control on any flush, but only a real instruction counts.
  assign kill         = bus.stall | bus.flush;
  assign count_bubble = bus.stall | (bus.flush & bus.ifid_valid);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.idex_rs      <= '0;
      bus.idex_rt      <= '0;
      bus.idex_rd      <= '0;
      bus.idex_rd1     <= '0;
      bus.idex_rd2     <= '0;
      bus.idex_imm     <= '0;
      bus.idex_ctrl    <= CTRL_NOP;
      bus.idex_valid   <= 1'b0;
      bus.bubble_count <= '0;
    end else begin
      bus.idex_rs    <= bus.ifid_rs;
      bus.idex_rt    <= bus.ifid_rt;
      bus.idex_rd    <= bus.ifid_rd;
      bus.idex_rd1   <= bus.ifid_rd1;
      bus.idex_rd2   <= bus.ifid_rd2;
      bus.idex_imm   <= bus.ifid_imm;
      bus.idex_ctrl  <= kill ? CTRL_NOP : bus.ifid_ctrl;
      bus.idex_valid <= bus.ifid_valid & ~kill;
      if (count_bubble && !(&bus.bubble_count)) begin
        bus.bubble_count <= bus.bubble_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 4-register MIPS core. It captures decoded operands, register numbers and control from the ID stage each cycle. It drives idex_rs/idex_rt into the forwarding unit and the ALU-side muxes. It inserts one bubble and holds PC and IF/ID whenever the EX-stage instruction is a load whose destination feeds the instruction in ID. It squashes the ID instruction on a taken-branch flush.

Parameters:
DATA_W, 8, datapath width of register operands and sign-extended immediate
REG_W, 2, register-number width (4 registers; r0 hard-wired zero)
CNT_W, 8, width of saturating bubble counter

Ports:
clock  in  1  single pipeline clock, rising edge
reset  in  1  synchronous, active-high
ifid_rs  in  REG_W  rs field of instruction in ID
ifid_rt  in  REG_W  rt field
ifid_rd  in  REG_W  rd field
ifid_rd1  in  DATA_W  register-file read data for rs
ifid_rd2  in  DATA_W  register-file read data for rt
ifid_imm  in  DATA_W  sign-extended immediate
ifid_ctrl  in  9  {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, Branch, ALUOp[1:0]} from decoder
ifid_valid  in  1  ID holds a real instruction
flush  in  1  taken branch resolved downstream; squash ID instruction
idex_rs, idex_rt, idex_rd  out  REG_W  registered register numbers (to forwarding unit)
idex_rd1, idex_rd2, idex_imm  out  DATA_W  registered operands
idex_ctrl  out  9  registered control, same bit order as ifid_ctrl
idex_valid  out  1  EX holds a real instruction
stall  out  1  combinational load-use hazard indication
pc_write  out  1  ~stall; PC update enable
ifid_write  out  1  ~stall; IF/ID update enable
bubble_count  out  CNT_W  saturating count of bubbles inserted (stalls + flushes)

Behaviour:
- Reset (synchronous): all idex_* outputs, idex_valid and bubble_count cleared to 0 on the clock edge with reset high. stall then evaluates 0, so pc_write=ifid_write=1.
- hazard = idex_valid & idex_ctrl.MemRead & (idex_rt != 0) & ifid_valid & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt)).
- stall = hazard & ~flush. Purely combinational, same cycle. No registered delay.
- Normal cycle (no hazard, no flush): every idex_* output loads the corresponding ifid_* input. idex_valid <= ifid_valid. Latency is 1 cycle.
- Stall cycle: idex_ctrl <= 0 and idex_valid <= 0 (bubble). Register numbers and data still load (don't-care, harmless). pc_write=ifid_write=0, so the same instruction is re-presented next cycle. The bubble clears MemRead, so the stall lasts exactly 1 cycle per load.
- Flush cycle: idex_ctrl <= 0 and idex_valid <= 0. Flush has priority over hazard; stall is forced 0 so IF/ID may refill.
- bubble_count increments on any cycle where a bubble is inserted: stall, or flush with ifid_valid=1. It saturates at all-ones and does not wrap.
- Bubble-only inputs (ifid_valid=0) pass through with control as given; the decoder guarantees zero ctrl then.
- r0 destination never causes a stall (load to r0 is discarded).
- Reset asserted mid-stall: reset wins, outputs cleared, stall drops the next cycle.
- Back-to-back loads: load A then dependent load B gives 1 stall. If B then feeds C, a second, independent stall occurs.

Decomposition:
- Shared package/header: ctrl bit-index constants (CTRL_REGWRITE..CTRL_ALUOP), CTRL_W=9, REG_W, DATA_W, and a CTRL_NOP=0 constant. These are also used by the EX/MEM stage and the forwarding unit.
- One natural sub-module: hazard_detect. It is combinational and produces hazard/stall/pc_write/ifid_write.
- The register bank and counter stay in idex_stage.

Test Plan:
- Reset held 2 cycles with random inputs -> all idex_* = 0, bubble_count = 0, stall = 0, pc_write = 1.
- Pass-through: ifid_rs=1, rt=2, rd=3, rd1=8'h5A, imm=8'hF0, ctrl=RegWrite|RegDst, valid=1 -> the next cycle shows identical idex_* values, stall=0.
- Load-use: EX holds a load (MemRead=1, idex_rt=2); ID has ifid_rs=2 -> stall=1 that cycle. The next cycle idex_ctrl=0 and idex_valid=0, bubble_count=1. The following cycle the re-presented instruction is captured and stall=0.
- Load to r0 (idex_rt=0) with ifid_rs=0 -> stall=0, no bubble.
- Simultaneous hazard and flush=1 -> stall=0, pc_write=1, idex_ctrl=0 next cycle, bubble_count increments by exactly 1.
- Saturation: force 300 flush cycles with ifid_valid=1 -> bubble_count holds at 8'hFF.
